// File: rtl/sdp_scan_ctrl.sv
// Scan controller for an 8-digit active-low seven-segment display with a double-buffered frame.
// Optional build macro: SDP_LEADING_ZERO_BLANK_EN (blank leading zero digits at commit).
module sdp_scan_ctrl #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_in,
  input  logic        load,
  output logic        load_ack,
  output logic [2:0]  dig_sel,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYC - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  dig_sel_q, dig_sel_d;
  logic [31:0] act_data_q, act_data_d;
  logic [7:0]  act_dp_q, act_dp_d;
  logic [7:0]  act_en_q, act_en_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic [7:0]  pend_dp_q, pend_dp_d;
  logic [7:0]  pend_en_q, pend_en_d;
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        load_ack_q, load_ack_d;
  logic        frame_tick_q, frame_tick_d;
  logic        last_cyc;
  logic        boundary;
  logic [3:0]  nibble;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

`ifdef SDP_LEADING_ZERO_BLANK_EN
  // Walk down from digit 7 clearing enables while the nibble is zero; a lit dp pins the digit.
  function automatic logic [7:0] lead_zero_en(input logic [31:0] d, input logic [7:0] p,
                                              input logic [7:0] e);
    logic [7:0] m;
    logic       blanking;
    m        = e;
    blanking = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (blanking && (d[4*k +: 4] == 4'h0) && !p[k]) m[k] = 1'b0;
      else blanking = 1'b0;
    end
    return m;
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    load_ack_d   = 1'b0;
    seg_d        = seg_q;
    dp_d         = dp_q;
    an_d         = 8'hFF;
    nibble       = 4'h0;

    last_cyc     = (cnt_q == CNT_LAST);
    boundary     = last_cyc && (dig_sel_q == 3'd7);
    cnt_d        = last_cyc ? '0 : cnt_q + 1'b1;
    dig_sel_d    = last_cyc ? dig_sel_q + 3'd1 : dig_sel_q;
    frame_tick_d = boundary;

    case (state_q)
      ST_BLANK: if (cnt_q == CNT_BLANK_END) state_d = ST_SHOW;
      ST_SHOW:  if (last_cyc) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    // Commit reads the pending buffer as it stood before this cycle's load.
    if (boundary && pend_valid_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
`ifdef SDP_LEADING_ZERO_BLANK_EN
      act_en_d     = lead_zero_en(pend_data_q, pend_dp_q, pend_en_q);
`else
      act_en_d     = pend_en_q;
`endif
      pend_valid_d = 1'b0;
      load_ack_d   = 1'b1;
    end

    if (load) begin
      pend_data_d  = data_in;
      pend_dp_d    = dp_in;
      pend_en_d    = en_in;
      pend_valid_d = 1'b1;
    end

    // Segments only move on entry to BLANK, so they are settled before any anode turns on.
    if (last_cyc) begin
      nibble = act_data_d[{dig_sel_d, 2'b00} +: 4];
      if (act_en_d[dig_sel_d]) begin
        seg_d = hex_glyph(nibble);
        dp_d  = ~act_dp_d[dig_sel_d];
      end else begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end
    end

    if ((state_d == ST_SHOW) && act_en_d[dig_sel_d]) an_d[dig_sel_d] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      dig_sel_q    <= 3'd0;
      act_data_q   <= 32'h0;
      act_dp_q     <= 8'h0;
      act_en_q     <= 8'h0;
      pend_data_q  <= 32'h0;
      pend_dp_q    <= 8'h0;
      pend_en_q    <= 8'h0;
      pend_valid_q <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dig_sel_q    <= dig_sel_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      load_ack_q   <= load_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign load_ack   = load_ack_q;
  assign dig_sel    = dig_sel_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sdp_scan_ctrl.sv
// Directed bench for sdp_scan_ctrl with DIV=8, BLANK_CYC=2 (64-cycle frame).
module tb_sdp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] data_in = 32'h0;
  logic [7:0]  dp_in = 8'h0;
  logic [7:0]  en_in = 8'h0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [2:0]  dig_sel;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sdp_scan_ctrl #(.DIV(8), .BLANK_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .en_in     (en_in),
    .load      (load),
    .load_ack  (load_ack),
    .dig_sel   (dig_sel),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dpi;
    logic [7:0]  en;
    logic [55:0] segs;  // expected seg per digit, digit 0 in [6:0]
    logic [7:0]  dpn;   // expected active-low dp per digit
    logic [7:0]  lit;   // digits whose anode goes low
  } vec_t;

  vec_t vecs[4];

  localparam logic [55:0] BLANK_SEGS = {8{7'h7F}};

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    data_in = d;
    dp_in   = p;
    en_in   = e;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step();
      if (load_ack === 1'b1) seen = 1'b1;
    end
    chk({name, "_ack_seen"}, 0, 32'(seen), 32'd1);
  endtask

  // Checks one full frame starting at slot 0 cycle 0; leaves the bench at the next frame start.
  task automatic walk(input string name, input logic [55:0] segs, input logic [7:0] dpn,
                      input logic [7:0] lit, input logic tick0, input logic ack0);
    for (int i = 0; i < 64; i++) begin
      int d;
      int c;
      logic [7:0]  ea;
      logic [20:0] exp_v;
      logic [20:0] act_v;
      d  = i / 8;
      c  = i % 8;
      ea = 8'hFF;
      if (c >= 2 && lit[d]) ea[d] = 1'b0;
      exp_v = {3'(d), ea, segs[7*d +: 7], dpn[d], (i == 0) ? tick0 : 1'b0,
               (i == 0) ? ack0 : 1'b0};
      act_v = {dig_sel, an, seg, dp, frame_tick, load_ack};
      chk(name, i, 32'(act_v), 32'(exp_v));
      step();
    end
  endtask

  initial begin
    vecs[0] = '{32'h76543210, 8'h00, 8'hFF,
                {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'hFF, 8'hFF};
    vecs[1] = '{32'hFEDCBA98, 8'h81, 8'hFF,
                {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}, 8'h7E, 8'hFF};
    vecs[2] = '{32'h00000000, 8'hFF, 8'h05,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h40}, 8'hFA, 8'h05};
`ifdef SDP_LEADING_ZERO_BLANK_EN
    vecs[3] = '{32'h00000120, 8'h00, 8'hFF,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40}, 8'hFF, 8'h07};
`else
    vecs[3] = '{32'h00000120, 8'h00, 8'hFF,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40}, 8'hFF, 8'hFF};
`endif

    // Reset values while rst_n is held low
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 0, 32'({dig_sel, an, seg, dp, frame_tick, load_ack}),
        32'({3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Idle after reset: blank display, tick once per 64 cycles, no ack
    walk("idle_f0", BLANK_SEGS, 8'hFF, 8'h00, 1'b0, 1'b0);
    walk("idle_f1", BLANK_SEGS, 8'hFF, 8'h00, 1'b1, 1'b0);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      load_frame(vecs[v].data, vecs[v].dpi, vecs[v].en);
      wait_ack($sformatf("vec%0d", v));
      walk($sformatf("vec%0d", v), vecs[v].segs, vecs[v].dpn, vecs[v].lit, 1'b1, 1'b1);
    end

    // Two loads in one frame: newest wins, one ack only
    load_frame(32'h11111111, 8'h00, 8'hFF);
    repeat (4) step();
    load_frame(32'h22222222, 8'h00, 8'hFF);
    wait_ack("dbl_load");
    walk("dbl_load_f0", {8{7'h24}}, 8'hFF, 8'hFF, 1'b1, 1'b1);
    walk("dbl_load_f1", {8{7'h24}}, 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Load on the boundary cycle: old pending commits now, new one a frame later
    load_frame(32'hAAAAAAAA, 8'h00, 8'hFF);
    repeat (62) step();
    load_frame(32'h55555555, 8'h00, 8'hFF);
    walk("bnd_f0", {8{7'h08}}, 8'hFF, 8'hFF, 1'b1, 1'b1);
    walk("bnd_f1", {8{7'h12}}, 8'hFF, 8'hFF, 1'b1, 1'b1);
    walk("bnd_f2", {8{7'h12}}, 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Asynchronous reset during digit 3 SHOW
    repeat (28) step();
    chk("pre_rst_an", 28, 32'(an), 32'(8'hF7));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 0, 32'({dig_sel, an, seg, dp, frame_tick, load_ack}),
        32'({3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    walk("post_rst_f0", BLANK_SEGS, 8'hFF, 8'h00, 1'b0, 1'b0);
    walk("post_rst_f1", BLANK_SEGS, 8'hFF, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
